// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: geometry defaults
// (shared with the instruction memory) and the loader state encoding.
package imem_loader_pkg;

   localparam int unsigned AddrWDefault = 10;
   localparam int unsigned DataWDefault = 32;
   localparam int unsigned BytesPerWord = 4;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StHdrHi = 3'd1,
      StHdrLo = 3'd2,
      StData  = 3'd3,
      StWrite = 3'd4,
      StDone  = 3'd5
   } state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian 4-byte shift register; full_o flags the byte that completes a word.
module word_assembler (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        full_o
);

   logic [31:0] word_q;
   logic [1:0]  cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (clear_i) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (shift_i) begin
         word_q <= {word_q[23:0], byte_i};
         cnt_q  <= cnt_q + 2'd1;
      end
   end

   // High during the accept of the 4th byte, so the loader enters WRITE on that edge.
   assign full_o = shift_i && (cnt_q == 2'd3);
   assign word_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a counted, big-endian program image into instruction memory and
// holds the CPU in reset until every word has been written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = AddrWDefault,
   parameter int unsigned DATA_W = DataWDefault
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [7:0]        byte_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              cpu_hold_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [16:0] Capacity = 17'(1) << ADDR_W;

   state_e            state_q;
   logic [15:0]       count_q;
   logic [ADDR_W-1:0] index_q;
   logic              byte_ready_q;
   logic              mem_we_q;
   logic              cpu_hold_q;
   logic              done_q;
   logic              err_q;

   logic        accept;
   logic [15:0] hdr_count;
   logic        last_word;
   logic        asm_clear;
   logic        asm_shift;
   logic        asm_full;
   logic [31:0] asm_word;

   assign accept    = byte_valid_i && byte_ready_q;
   assign hdr_count = {count_q[15:8], byte_i};
   assign last_word = (16'(index_q) == (count_q - 16'd1));
   assign asm_clear = (state_q == StHdrLo) && accept;
   assign asm_shift = (state_q == StData) && accept;

   word_assembler u_word_assembler (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (asm_clear),
      .shift_i (asm_shift),
      .byte_i  (byte_i),
      .word_o  (asm_word),
      .full_o  (asm_full)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         count_q      <= '0;
         index_q      <= '0;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         cpu_hold_q   <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (start_i) begin
                  state_q      <= StHdrHi;
                  byte_ready_q <= 1'b1;
                  cpu_hold_q   <= 1'b1;
                  done_q       <= 1'b0;
                  err_q        <= 1'b0;
               end
            end
            StHdrHi: begin
               if (accept) begin
                  count_q[15:8] <= byte_i;
                  state_q       <= StHdrLo;
               end
            end
            StHdrLo: begin
               if (accept) begin
                  count_q[7:0] <= byte_i;
                  if (hdr_count == 16'd0) begin
                     state_q      <= StDone;
                     byte_ready_q <= 1'b0;
                     cpu_hold_q   <= 1'b0;
                     done_q       <= 1'b1;
                  end else if (17'(hdr_count) > Capacity) begin
                     state_q      <= StIdle;
                     byte_ready_q <= 1'b0;
                     err_q        <= 1'b1;
                  end else begin
                     index_q <= '0;
                     state_q <= StData;
                  end
               end
            end
            StData: begin
               if (asm_full) begin
                  state_q      <= StWrite;
                  byte_ready_q <= 1'b0;
                  mem_we_q     <= 1'b1;
               end
            end
            StWrite: begin
               if (last_word) begin
                  state_q    <= StDone;
                  cpu_hold_q <= 1'b0;
                  done_q     <= 1'b1;
               end else begin
                  index_q      <= index_q + 1'b1;
                  state_q      <= StData;
                  byte_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q      <= StIdle;
               byte_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign byte_ready_o = byte_ready_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = index_q;
   assign mem_wdata_o  = DATA_W'(asm_word);
   assign cpu_hold_o   = cpu_hold_q;
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader with a byte-stream reference model and write log.
module tb_imem_loader;

   localparam int unsigned AW  = 10;
   localparam int unsigned DW  = 32;
   localparam int          Cap = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    byte_in = '0;
   logic          byte_valid = 1'b0;
   logic          byte_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          err;

   int checks = 0;
   int errors = 0;

   // Bench-side record of every write the DUT makes.
   int          log_addr[$];
   logic [31:0] log_data[$];

   // Byte-stream model: position in the current load decides what a byte means.
   logic        m_busy = 1'b0;
   logic        m_wr = 1'b0;
   logic        m_done = 1'b0;
   logic        m_err = 1'b0;
   int          m_pos = 0;
   int          m_n = 0;
   int          m_idx = 0;
   logic [7:0]  m_hi = '0;
   logic [31:0] m_word = '0;
   int          m_wr_addr = 0;
   logic [31:0] m_wr_data = '0;

   logic [31:0] img[Cap];
   logic        noise = 1'b0;

   imem_loader #(
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .byte_i       (byte_in),
      .byte_valid_i (byte_valid),
      .byte_ready_o (byte_ready),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_wdata_o  (mem_wdata),
      .cpu_hold_o   (cpu_hold),
      .done_o       (done),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare outputs against the model mid-cycle, then advance the model across the next edge.
   always @(negedge clk) begin
      logic nwr;
      chk("byte_ready", 32'(byte_ready), 32'(m_busy && !m_wr));
      chk("mem_we", 32'(mem_we), 32'(m_wr));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("cpu_hold", 32'(cpu_hold), 32'(!m_done));
      if (m_wr) begin
         chk("mem_addr", 32'(mem_addr), 32'(m_wr_addr));
         chk("mem_wdata", mem_wdata, m_wr_data);
      end
      if (mem_we) begin
         log_addr.push_back(int'(mem_addr));
         log_data.push_back(mem_wdata);
      end
      nwr = 1'b0;
      if (rst) begin
         m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
         m_pos = 0; m_n = 0; m_idx = 0; m_word = '0;
      end else if (m_wr) begin
         if (m_idx == m_n - 1) begin
            m_busy = 1'b0;
            m_done = 1'b1;
         end else begin
            m_idx++;
         end
      end else if (m_busy && byte_valid) begin
         if (m_pos == 0) begin
            m_hi = byte_in;
         end else if (m_pos == 1) begin
            m_n = int'({m_hi, byte_in});
            m_idx = 0;
            if (m_n == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end else if (m_n > Cap) begin
               m_busy = 1'b0;
               m_err = 1'b1;
            end
         end else begin
            m_word = {m_word[23:0], byte_in};
            if ((m_pos - 2) % 4 == 3) begin
               nwr = 1'b1;
               m_wr_addr = m_idx;
               m_wr_data = m_word;
            end
         end
         m_pos++;
      end else if (!m_busy && start) begin
         m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0; m_pos = 0;
      end
      m_wr = nwr;
   end

   // All driving happens 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gapmax);
      logic acc;
      int   n;
      repeat ($urandom_range(gapmax, 0)) begin
         byte_valid = 1'b0;
         tick();
      end
      byte_valid = 1'b1;
      byte_in    = b;
      acc        = 1'b0;
      n          = 0;
      while (!acc && n < 100) begin
         start = noise && ($urandom_range(7, 0) == 0);
         @(negedge clk);
         acc = byte_ready;
         tick();
         n++;
      end
      start      = 1'b0;
      byte_valid = 1'b0;
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout: byte %h not accepted within 100 cycles", b);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gapmax);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gapmax);
   endtask

   initial begin
      int base;
      logic [31:0] w;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      tick();

      // Idle with a byte offered: nothing is consumed.
      byte_valid = 1'b1;
      byte_in    = 8'h55;
      repeat (5) tick();
      chk("idle_byte_ready", 32'(byte_ready), 32'd0);
      byte_valid = 1'b0;

      // Two-word image.
      base = log_addr.size();
      do_start();
      chk("start_ready", 32'(byte_ready), 32'd1);
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_word(32'h24080005, 0);
      send_word(32'hAC090010, 0);
      repeat (3) tick();
      chk("two_count", 32'(log_addr.size() - base), 32'd2);
      chk("two_w0_data", log_data[base], 32'h24080005);
      chk("two_w0_addr", 32'(log_addr[base]), 32'd0);
      chk("two_w1_data", log_data[base+1], 32'hAC090010);
      chk("two_w1_addr", 32'(log_addr[base+1]), 32'd1);
      chk("two_done", 32'(done), 32'd1);
      chk("two_hold", 32'(cpu_hold), 32'd0);

      // Empty image, then oversize header.
      base = log_addr.size();
      do_start();
      send_byte(8'h00, 1);
      send_byte(8'h00, 1);
      repeat (3) tick();
      chk("empty_writes", 32'(log_addr.size() - base), 32'd0);
      chk("empty_done", 32'(done), 32'd1);
      do_start();
      chk("restart_done_clr", 32'(done), 32'd0);
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      repeat (3) tick();
      chk("big_err", 32'(err), 32'd1);
      chk("big_hold", 32'(cpu_hold), 32'd1);
      chk("big_ready", 32'(byte_ready), 32'd0);

      // Full-capacity load with random gaps and stray start pulses.
      for (int i = 0; i < Cap; i++) img[i] = $urandom;
      base  = log_addr.size();
      do_start();
      chk("full_err_clr", 32'(err), 32'd0);
      noise = 1'b1;
      send_byte(8'h04, 2);
      send_byte(8'h00, 2);
      for (int i = 0; i < Cap; i++) send_word(img[i], 2);
      noise = 1'b0;
      repeat (3) tick();
      chk("full_count", 32'(log_addr.size() - base), 32'(Cap));
      if (log_addr.size() - base == Cap) begin
         for (int i = 0; i < Cap; i++) begin
            chk("full_addr", 32'(log_addr[base+i]), 32'(i));
            chk("full_data", log_data[base+i], img[i]);
         end
      end
      chk("full_done", 32'(done), 32'd1);

      // Reset after two of four words, then a fresh one-word image.
      base = log_addr.size();
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      send_word(32'h11223344, 1);
      send_word(32'h55667788, 1);
      w = 32'h99AABBCC;
      send_byte(w[31:24], 0);
      send_byte(w[23:16], 0);
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (2) tick();
      chk("abort_writes", 32'(log_addr.size() - base), 32'd2);
      chk("abort_hold", 32'(cpu_hold), 32'd1);
      base = log_addr.size();
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_word(32'hDEADBEEF, 1);
      repeat (3) tick();
      chk("after_rst_count", 32'(log_addr.size() - base), 32'd1);
      if (log_addr.size() > base) begin
         chk("after_rst_data", log_data[base], 32'hDEADBEEF);
         chk("after_rst_addr", 32'(log_addr[base]), 32'd0);
      end
      chk("after_rst_done", 32'(done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
